conv_cfg_decoder: RTL and testbench
===================================

Name: conv_cfg_decoder

Overview:
- Parametrised next-generation instruction decoder for the convolution core. Uses a valid/ready input handshake.
- Double-buffers its configuration: LF/LS/LI instructions load a shadow register set while a convolution runs from the active set. DC commits shadow to active and launches the core.
- Adds an explicit IDLE/RUN state machine, a start pulse and sticky error reporting. Sits between the instruction FIFO read port and the conv controller / address generators.

Parameters:
- INST_W, 32, instruction width.
- OP_W, 4, opcode field width, at bits [INST_W-1 -: OP_W].
- FSIZE_W, 4, filter size field width.
- FNUM_W, 4, filter count field width.
- OFF_W, 20, filter and image offset width, at bits [OFF_W-1:0].
- DIM_W, 12, image height/width field width. Width at [DIM_W-1:0], height at [2*DIM_W-1:DIM_W].
- Elaboration check: OP_W+FSIZE_W+FNUM_W+OFF_W <= INST_W and OP_W+2*DIM_W <= INST_W; otherwise $error.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- in_inst, in, INST_W, instruction word.
- in_valid, in, 1, in_inst valid.
- in_ready, out, 1, decoder accepts in_inst this cycle.
- filter_offset, out, OFF_W, active filter base offset.
- filter_size, out, FSIZE_W, active filter size.
- filter_num, out, FNUM_W, active filter count.
- img_offset, out, OFF_W, active image base offset.
- img_height, out, DIM_W, active image height.
- img_width, out, DIM_W, active image width.
- shadow_flags, out, 3, shadow-loaded bits: [0] LF, [1] LS, [2] LI.
- conv_start, out, 1, one-cycle launch pulse.
- busy, out, 1, state == RUN.
- conv_done, in, 1, core finished; single-cycle pulse.
- err, out, 1, sticky error.
- err_code, out, 2, first error cause: 0 none, 1 illegal opcode, 2 DC incomplete, 3 bad filter.
- err_clr, in, 1, clears err/err_code.

Behaviour:
- Reset (asynchronous, rst_n low): all active and shadow registers 0, shadow_flags 0, conv_start 0, state IDLE (busy 0), err 0, err_code 0. A mid-run reset aborts the run immediately; no start pulse is issued.
- Handshake: accept = in_valid && in_ready. in_ready is combinational: low only when in_inst opcode == OP_DC and state == RUN; high otherwise, including in_valid low.
- Accepted LF:
  - If the size field or num field is 0: raise error code 3. Shadow and flags unchanged.
  - Else: shadow size/num/offset load at the next edge; shadow_flags[0] = 1.
- Accepted LS: shadow height/width load; shadow_flags[1] = 1. A 0 dimension is legal.
- Accepted LI: shadow img offset loads; shadow_flags[2] = 1.
- Reloading an already-flagged field overwrites it; the flag stays set. Shadow loading is allowed in both IDLE and RUN. Active outputs never change during RUN.
- Accepted DC (only possible in IDLE):
  - If shadow_flags == 3'b111: at the next edge, shadow is copied to active, shadow_flags clears to 0, state goes to RUN, busy = 1, and conv_start = 1 for exactly that one cycle.
  - Else: raise error code 2. State, shadow and active unchanged.
- Accepted OP_CLR: shadow_flags = 0, err = 0, err_code = 0. Active set and state untouched.
- Accepted unknown opcode: consumed; raise error code 1; no other effect.
- RUN to IDLE: conv_done in RUN sets state IDLE at the next edge. conv_done in IDLE is ignored.
- DC vs conv_done in the same cycle: DC is held (in_ready low), accepted the following cycle. Minimum conv_done to next conv_start is 2 cycles.
- Error reporting:
  - err is sticky. err_code latches only the first error while err = 1.
  - err_clr (or CLR) clears both.
  - If err_clr coincides with a new error, the new error wins: err = 1, code = new cause.
- Latency: instruction accept to register/flag update is 1 cycle. DC accept to conv_start is 1 cycle.

Decomposition:
- Shared package conv_pkg:
  - Opcode localparams OP_LF=4'h1, OP_LS=4'h2, OP_LI=4'h3, OP_DC=4'h4, OP_CLR=4'hF.
  - enum state_e {IDLE, RUN}.
  - enum err_e {ERR_NONE, ERR_ILLEGAL, ERR_INCOMPLETE, ERR_BADFILT}.
  - Packed struct conv_cfg_t holding the six configuration fields; width parameters as package defaults.
- One sub-module, conv_cfg_bank: a shadow+active register pair with load/commit strobes, instantiated once per conv_cfg_t.

Test Plan:
- LF size=3 num=2 off=0x100; LS 28x28; LI off=0x2000; DC -> shadow_flags 1,3,7 in turn. Cycle after DC: conv_start=1 for 1 cycle, filter_size=3, img_height=28, img_offset=0x2000, busy=1.
- In RUN, load LF size=5, LI 0x3000, then present DC -> in_ready=0 on DC, active filter_size stays 3. Pulse conv_done -> busy=0 next cycle. Without LS, DC then accepted -> err=1, err_code=2, no conv_start.
- LF size=0 -> err_code=3, shadow_flags[0] unchanged. Then opcode 4'h9 -> err_code stays 3. Then err_clr together with another 4'h9 -> err=1, err_code=1.
- conv_done pulse while DC waits in RUN -> DC accepted 1 cycle later, conv_start 2 cycles after conv_done.
- Assert rst_n low during RUN with in_valid=1 -> all outputs 0 immediately, busy=0, in_ready=1.
- OP_CLR with flags=7 and err=1 -> flags=0, err=0; active outputs unchanged.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared opcodes, state/error enums and the default configuration record
// for the convolution core instruction decoder.
package conv_pkg;

    localparam int DEF_INST_W  = 32;
    localparam int DEF_OP_W    = 4;
    localparam int DEF_FSIZE_W = 4;
    localparam int DEF_FNUM_W  = 4;
    localparam int DEF_OFF_W   = 20;
    localparam int DEF_DIM_W   = 12;

    localparam logic [3:0] OP_LF  = 4'h1;
    localparam logic [3:0] OP_LS  = 4'h2;
    localparam logic [3:0] OP_LI  = 4'h3;
    localparam logic [3:0] OP_DC  = 4'h4;
    localparam logic [3:0] OP_CLR = 4'hF;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_ILLEGAL,
        ERR_INCOMPLETE,
        ERR_BADFILT
    } err_e;

    typedef struct packed {
        logic [DEF_OFF_W-1:0]   filter_offset;
        logic [DEF_FSIZE_W-1:0] filter_size;
        logic [DEF_FNUM_W-1:0]  filter_num;
        logic [DEF_OFF_W-1:0]   img_offset;
        logic [DEF_DIM_W-1:0]   img_height;
        logic [DEF_DIM_W-1:0]   img_width;
    } conv_cfg_t;

endpackage

// File: rtl/conv_cfg_bank.sv
// Shadow/active configuration register pair: shadow loads while a run
// uses the active copy; commit copies shadow into active.
module conv_cfg_bank
    import conv_pkg::*;
#(
    parameter type cfg_t = conv_cfg_t
) (
    input  logic clk,
    input  logic rst_n,
    input  cfg_t shadow_d,
    input  logic shadow_load,
    input  logic commit,
    output cfg_t shadow,
    output cfg_t active
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (shadow_load) begin
            shadow <= shadow_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= '0;
        end else if (commit) begin
            active <= shadow;
        end
    end

endmodule

// File: rtl/conv_cfg_decoder.sv
// Instruction decoder for the convolution core: double-buffered config,
// IDLE/RUN sequencing, one-cycle start pulse and sticky error reporting.
module conv_cfg_decoder
    import conv_pkg::*;
#(
    parameter int INST_W  = DEF_INST_W,
    parameter int OP_W    = DEF_OP_W,
    parameter int FSIZE_W = DEF_FSIZE_W,
    parameter int FNUM_W  = DEF_FNUM_W,
    parameter int OFF_W   = DEF_OFF_W,
    parameter int DIM_W   = DEF_DIM_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INST_W-1:0]  in_inst,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [OFF_W-1:0]   filter_offset,
    output logic [FSIZE_W-1:0] filter_size,
    output logic [FNUM_W-1:0]  filter_num,
    output logic [OFF_W-1:0]   img_offset,
    output logic [DIM_W-1:0]   img_height,
    output logic [DIM_W-1:0]   img_width,
    output logic [2:0]         shadow_flags,
    output logic               conv_start,
    output logic               busy,
    input  logic               conv_done,
    output logic               err,
    output logic [1:0]         err_code,
    input  logic               err_clr
);

    if ((OP_W + FSIZE_W + FNUM_W + OFF_W > INST_W) || (OP_W + 2*DIM_W > INST_W)) begin : g_width_check
        $error("conv_cfg_decoder: instruction fields do not fit in INST_W");
    end

    typedef struct packed {
        logic [OFF_W-1:0]   filter_offset;
        logic [FSIZE_W-1:0] filter_size;
        logic [FNUM_W-1:0]  filter_num;
        logic [OFF_W-1:0]   img_offset;
        logic [DIM_W-1:0]   img_height;
        logic [DIM_W-1:0]   img_width;
    } cfg_t;

    // LF layout: offset in the low bits, size above it, count above size.
    logic [OP_W-1:0]    opcode;
    logic [OFF_W-1:0]   lf_offset;
    logic [FSIZE_W-1:0] lf_size;
    logic [FNUM_W-1:0]  lf_num;
    logic [DIM_W-1:0]   ls_width;
    logic [DIM_W-1:0]   ls_height;

    assign opcode    = in_inst[INST_W-1 -: OP_W];
    assign lf_offset = in_inst[OFF_W-1:0];
    assign lf_size   = in_inst[OFF_W +: FSIZE_W];
    assign lf_num    = in_inst[OFF_W+FSIZE_W +: FNUM_W];
    assign ls_width  = in_inst[DIM_W-1:0];
    assign ls_height = in_inst[DIM_W +: DIM_W];

    state_e     state, state_d;
    err_e       err_q, err_d;
    logic       err_flag, err_flag_d;
    logic [2:0] flags, flags_d;
    logic       accept;
    logic       shadow_load;
    logic       commit;
    logic       clr_cmd;
    logic       new_err;
    err_e       new_code;
    cfg_t       shadow, shadow_d, active;

    assign in_ready = !((opcode == OP_W'(OP_DC)) && (state == RUN));
    assign accept   = in_valid && in_ready;

    always_comb begin
        shadow_d    = shadow;
        shadow_load = 1'b0;
        commit      = 1'b0;
        clr_cmd     = 1'b0;
        flags_d     = flags;
        new_err     = 1'b0;
        new_code    = ERR_NONE;
        if (accept) begin
            case (opcode)
                OP_W'(OP_LF): begin
                    if ((lf_size == '0) || (lf_num == '0)) begin
                        new_err  = 1'b1;
                        new_code = ERR_BADFILT;
                    end else begin
                        shadow_d.filter_offset = lf_offset;
                        shadow_d.filter_size   = lf_size;
                        shadow_d.filter_num    = lf_num;
                        shadow_load            = 1'b1;
                        flags_d[0]             = 1'b1;
                    end
                end
                OP_W'(OP_LS): begin
                    shadow_d.img_height = ls_height;
                    shadow_d.img_width  = ls_width;
                    shadow_load         = 1'b1;
                    flags_d[1]          = 1'b1;
                end
                OP_W'(OP_LI): begin
                    shadow_d.img_offset = lf_offset;
                    shadow_load         = 1'b1;
                    flags_d[2]          = 1'b1;
                end
                OP_W'(OP_DC): begin
                    if (flags == 3'b111) begin
                        commit  = 1'b1;
                        flags_d = 3'b000;
                    end else begin
                        new_err  = 1'b1;
                        new_code = ERR_INCOMPLETE;
                    end
                end
                OP_W'(OP_CLR): begin
                    clr_cmd = 1'b1;
                    flags_d = 3'b000;
                end
                default: begin
                    new_err  = 1'b1;
                    new_code = ERR_ILLEGAL;
                end
            endcase
        end
    end

    // A fresh error beats a simultaneous clear; otherwise the first cause sticks.
    always_comb begin
        err_flag_d = err_flag;
        err_d      = err_q;
        if (new_err) begin
            err_flag_d = 1'b1;
            if (!err_flag || err_clr || clr_cmd) begin
                err_d = new_code;
            end
        end else if (err_clr || clr_cmd) begin
            err_flag_d = 1'b0;
            err_d      = ERR_NONE;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (commit)    state_d = RUN;
            RUN:     if (conv_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags      <= 3'b000;
            err_flag   <= 1'b0;
            err_q      <= ERR_NONE;
            conv_start <= 1'b0;
        end else begin
            flags      <= flags_d;
            err_flag   <= err_flag_d;
            err_q      <= err_d;
            conv_start <= commit;
        end
    end

    conv_cfg_bank #(
        .cfg_t(cfg_t)
    ) u_bank (
        .clk        (clk),
        .rst_n      (rst_n),
        .shadow_d   (shadow_d),
        .shadow_load(shadow_load),
        .commit     (commit),
        .shadow     (shadow),
        .active     (active)
    );

    assign filter_offset = active.filter_offset;
    assign filter_size   = active.filter_size;
    assign filter_num    = active.filter_num;
    assign img_offset    = active.img_offset;
    assign img_height    = active.img_height;
    assign img_width     = active.img_width;
    assign shadow_flags  = flags;
    assign busy          = (state == RUN);
    assign err           = err_flag;
    assign err_code      = err_q;

endmodule

// File: tb/tb_conv_cfg_decoder.sv
// Self-checking bench for conv_cfg_decoder: directed scenarios followed by
// random instruction traffic, all compared against a cycle-level model.
module tb_conv_cfg_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_inst;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] filter_offset;
    logic [3:0]  filter_size;
    logic [3:0]  filter_num;
    logic [19:0] img_offset;
    logic [11:0] img_height;
    logic [11:0] img_width;
    logic [2:0]  shadow_flags;
    logic        conv_start;
    logic        busy;
    logic        conv_done;
    logic        err;
    logic [1:0]  err_code;
    logic        err_clr;

    int total = 0;
    int bad   = 0;

    // Model: index 0 filter_offset, 1 size, 2 num, 3 img_offset, 4 height, 5 width.
    int       m_sh[6];
    int       m_act[6];
    bit [2:0] m_flags;
    bit       m_busy;
    bit       m_start;
    bit       m_err;
    int       m_code;

    always #5 clk = ~clk;

    conv_cfg_decoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_inst      (in_inst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .filter_offset(filter_offset),
        .filter_size  (filter_size),
        .filter_num   (filter_num),
        .img_offset   (img_offset),
        .img_height   (img_height),
        .img_width    (img_width),
        .shadow_flags (shadow_flags),
        .conv_start   (conv_start),
        .busy         (busy),
        .conv_done    (conv_done),
        .err          (err),
        .err_code     (err_code),
        .err_clr      (err_clr)
    );

    function automatic logic [31:0] mkLF(input int size, input int num, input int off);
        logic [3:0]  s = size[3:0];
        logic [3:0]  n = num[3:0];
        logic [19:0] o = off[19:0];
        return {4'h1, n, s, o};
    endfunction

    function automatic logic [31:0] mkLS(input int h, input int w);
        logic [11:0] hh = h[11:0];
        logic [11:0] ww = w[11:0];
        return {4'h2, 4'h0, hh, ww};
    endfunction

    function automatic logic [31:0] mkLI(input int off);
        logic [19:0] o = off[19:0];
        return {4'h3, 8'h00, o};
    endfunction

    function automatic logic [31:0] mkOp(input int op);
        logic [3:0] o = op[3:0];
        return {o, 28'h0};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 6; i++) begin
            m_sh[i]  = 0;
            m_act[i] = 0;
        end
        m_flags = 3'b000;
        m_busy  = 1'b0;
        m_start = 1'b0;
        m_err   = 1'b0;
        m_code  = 0;
    endtask

    task automatic modelStep(input logic [31:0] inst, input bit valid, input bit done, input bit clr);
        int op;
        bit acc;
        bit ne;
        int nc;
        bit clrc;
        bit start;
        bit busy_n;
        op     = int'(inst[31:28]);
        acc    = valid && !(op == 4 && m_busy);
        ne     = 1'b0;
        nc     = 0;
        clrc   = 1'b0;
        start  = 1'b0;
        busy_n = m_busy && !done;
        if (acc) begin
            case (op)
                1: begin
                    if (inst[23:20] == 4'd0 || inst[27:24] == 4'd0) begin
                        ne = 1'b1;
                        nc = 3;
                    end else begin
                        m_sh[0]    = int'(inst[19:0]);
                        m_sh[1]    = int'(inst[23:20]);
                        m_sh[2]    = int'(inst[27:24]);
                        m_flags[0] = 1'b1;
                    end
                end
                2: begin
                    m_sh[4]    = int'(inst[23:12]);
                    m_sh[5]    = int'(inst[11:0]);
                    m_flags[1] = 1'b1;
                end
                3: begin
                    m_sh[3]    = int'(inst[19:0]);
                    m_flags[2] = 1'b1;
                end
                4: begin
                    if (m_flags == 3'b111) begin
                        m_act   = m_sh;
                        m_flags = 3'b000;
                        start   = 1'b1;
                        busy_n  = 1'b1;
                    end else begin
                        ne = 1'b1;
                        nc = 2;
                    end
                end
                15: begin
                    m_flags = 3'b000;
                    clrc    = 1'b1;
                end
                default: begin
                    ne = 1'b1;
                    nc = 1;
                end
            endcase
        end
        if (ne) begin
            if (!m_err || clr || clrc) m_code = nc;
            m_err = 1'b1;
        end else if (clr || clrc) begin
            m_err  = 1'b0;
            m_code = 0;
        end
        m_busy  = busy_n;
        m_start = start;
    endtask

    task automatic checkAll();
        checkOutput("filter_offset", 32'(filter_offset), m_act[0]);
        checkOutput("filter_size",   32'(filter_size),   m_act[1]);
        checkOutput("filter_num",    32'(filter_num),    m_act[2]);
        checkOutput("img_offset",    32'(img_offset),    m_act[3]);
        checkOutput("img_height",    32'(img_height),    m_act[4]);
        checkOutput("img_width",     32'(img_width),     m_act[5]);
        checkOutput("shadow_flags",  32'(shadow_flags),  32'(m_flags));
        checkOutput("conv_start",    32'(conv_start),    32'(m_start));
        checkOutput("busy",          32'(busy),          32'(m_busy));
        checkOutput("err",           32'(err),           32'(m_err));
        checkOutput("err_code",      32'(err_code),      m_code);
    endtask

    // Drive one cycle of inputs, check in_ready before the edge and state after it.
    task automatic applyStimulus(input logic [31:0] inst, input bit valid, input bit done, input bit clr);
        @(negedge clk);
        in_inst   = inst;
        in_valid  = valid;
        conv_done = done;
        err_clr   = clr;
        #1;
        checkOutput("in_ready", 32'(in_ready), 32'(!(inst[31:28] == 4'h4 && m_busy)));
        @(posedge clk);
        modelStep(inst, valid, done, clr);
        #1;
        checkAll();
    endtask

    task automatic midRunReset();
        @(negedge clk);
        in_inst   = mkOp(4);
        in_valid  = 1'b1;
        conv_done = 1'b0;
        err_clr   = 1'b0;
        rst_n     = 1'b0;
        #1;
        modelReset();
        checkAll();
        checkOutput("in_ready_rst", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
    endtask

    initial begin
        int r;
        logic [31:0] inst;
        rst_n     = 1'b0;
        in_inst   = '0;
        in_valid  = 1'b0;
        conv_done = 1'b0;
        err_clr   = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkAll();
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] load shadow and launch");
        applyStimulus(mkLF(3, 2, 'h100), 1, 0, 0);
        applyStimulus(mkLS(28, 28), 1, 0, 0);
        applyStimulus(mkLI('h2000), 1, 0, 0);
        applyStimulus(mkOp(4), 1, 0, 0);
        checkOutput("launch_fsize", 32'(filter_size), 32'd3);
        checkOutput("launch_ioff",  32'(img_offset),  32'h2000);
        applyStimulus('0, 0, 0, 0);

        $display("[TB] reload during run, DC held, incomplete DC");
        applyStimulus(mkLF(5, 2, 'h500), 1, 0, 0);
        applyStimulus(mkLI('h3000), 1, 0, 0);
        applyStimulus(mkOp(4), 1, 0, 0);
        checkOutput("run_fsize", 32'(filter_size), 32'd3);
        applyStimulus(mkOp(4), 1, 1, 0);
        applyStimulus(mkOp(4), 1, 0, 0);
        checkOutput("incomplete_code", 32'(err_code), 32'd2);

        $display("[TB] error stickiness");
        applyStimulus('0, 0, 0, 1);
        applyStimulus(mkLF(0, 2, 'h10), 1, 0, 0);
        applyStimulus(mkOp(9), 1, 0, 0);
        checkOutput("sticky_code", 32'(err_code), 32'd3);
        applyStimulus(mkOp(9), 1, 0, 1);
        checkOutput("clr_vs_new", 32'(err_code), 32'd1);

        $display("[TB] DC waiting on conv_done");
        applyStimulus(mkLS(7, 9), 1, 0, 0);
        applyStimulus(mkOp(4), 1, 0, 0);
        applyStimulus(mkLF(4, 4, 'hABC), 1, 0, 0);
        applyStimulus(mkLS(16, 32), 1, 0, 0);
        applyStimulus(mkLI('h4444), 1, 0, 0);
        applyStimulus(mkOp(4), 1, 0, 0);
        applyStimulus(mkOp(4), 1, 1, 0);
        applyStimulus(mkOp(4), 1, 0, 0);
        applyStimulus('0, 0, 0, 0);

        $display("[TB] CLR with full flags and error");
        applyStimulus(mkLF(2, 1, 'h20), 1, 0, 0);
        applyStimulus(mkLS(3, 3), 1, 0, 0);
        applyStimulus(mkLI('h30), 1, 0, 0);
        applyStimulus(mkOp(7), 1, 0, 0);
        applyStimulus(mkOp(15), 1, 0, 0);

        $display("[TB] reset during run");
        midRunReset();
        applyStimulus('0, 0, 0, 0);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1: inst = mkLF($urandom_range(0, 15), $urandom_range(0, 15), $urandom);
                2:    inst = mkLS($urandom, $urandom);
                3:    inst = mkLI($urandom);
                4, 5: inst = mkOp(4);
                6:    inst = mkOp(15);
                7:    inst = mkOp(($urandom_range(0, 10) == 0) ? 0 : $urandom_range(5, 14));
                default: inst = mkLF($urandom_range(1, 15), $urandom_range(1, 15), $urandom);
            endcase
            applyStimulus(inst, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 9) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
